// File: rtl/cluster_frame_collector.sv
// cluster_frame_collector: gathers one cluster per pass into a frame word and queues frames in a FWFT FIFO.
// Optional `FRAME_DROP_CNT_EN adds a saturating drop_cnt output.
module cluster_frame_collector #(
  parameter int MXPASS     = 8,
  parameter int MXADRBITS  = 11,
  parameter int MXCNTBITS  = 3,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                                     clock,
  input  logic                                     reset,
  input  logic                                     found_in,
  input  logic [MXADRBITS-1:0]                     adr_in,
  input  logic [MXCNTBITS-1:0]                     cnt_in,
  input  logic [2:0]                               pass_in,
  output logic [MXPASS*(MXCNTBITS+MXADRBITS)-1:0]  frame_data,
  output logic                                     frame_valid,
  input  logic                                     frame_ready,
  output logic [$clog2(FIFO_DEPTH):0]              fifo_count,
  output logic                                     overflow
`ifdef FRAME_DROP_CNT_EN
  ,
  output logic [15:0]                              drop_cnt
`endif
);
  localparam int W  = MXCNTBITS + MXADRBITS;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [W-1:0]  INVALID = {{MXCNTBITS{1'b0}}, {MXADRBITS{1'b1}}};
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  typedef logic [MXPASS-1:0][W-1:0] frame_t;
  frame_t        slot_q, slot_d, data_q, data_d, new_frame;
  frame_t        mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] count_q, count_d, remain;
  logic          ovf_q, ovf_d;
  logic [W-1:0]  in_slot;
  logic          tag_ok, push, pop, full, push_ok, drop;
  always_comb begin
    in_slot   = found_in ? {cnt_in, adr_in} : INVALID;
    tag_ok    = int'(pass_in) < MXPASS;
    push      = tag_ok && pass_in == 3'(MXPASS - 1);
    pop       = count_q != '0 && frame_ready;
    full      = count_q == DEPTH_C;
    push_ok   = push && (!full || pop);
    drop      = push && full && !pop;
    slot_d    = slot_q;
    for (int k = 0; k < MXPASS; k++)
      if (tag_ok && pass_in == 3'(k)) slot_d[k] = in_slot;
    new_frame = slot_q;
    new_frame[MXPASS-1] = in_slot;
    wr_d      = push_ok ? wr_q + AW'(1) : wr_q;
    rd_d      = pop ? rd_q + AW'(1) : rd_q;
    remain    = count_q - CW'(pop);
    count_d   = remain + CW'(push_ok);
    // The output register always mirrors the entry that will be head after this edge.
    data_d    = remain != '0 ? mem_q[rd_d] : push_ok ? new_frame : data_q;
    ovf_d     = ovf_q | drop;
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      slot_q  <= {MXPASS{INVALID}};
      data_q  <= {MXPASS{INVALID}};
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      slot_q  <= slot_d;
      data_q  <= data_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end
  always_ff @(posedge clock) begin
    if (push_ok) mem_q[wr_q] <= new_frame;
  end
  assign frame_data  = data_q;
  assign frame_valid = count_q != '0;
  assign fifo_count  = count_q;
  assign overflow    = ovf_q;
`ifdef FRAME_DROP_CNT_EN
  logic [15:0] drop_cnt_q, drop_cnt_d;
  always_comb drop_cnt_d = (drop && drop_cnt_q != 16'hFFFF) ? drop_cnt_q + 16'd1 : drop_cnt_q;
  always_ff @(posedge clock or posedge reset) begin
    if (reset) drop_cnt_q <= '0;
    else drop_cnt_q <= drop_cnt_d;
  end
  assign drop_cnt = drop_cnt_q;
`endif
endmodule

// File: tb/tb_cluster_frame_collector.sv
// tb_cluster_frame_collector: directed checks of frame assembly, FIFO flow control, reset and illegal tags.
module tb_cluster_frame_collector;
  localparam logic [13:0] INV = 14'h07FF;
  logic         clock = 1'b0, reset = 1'b1;
  logic         found_in = 1'b0;
  logic [10:0]  adr_in = 11'h7FF;
  logic [2:0]   cnt_in = 3'd0, pass_in = 3'd0;
  logic         frame_ready = 1'b0, ready6 = 1'b0;
  logic [111:0] frame_data;
  logic [83:0]  frame_data6;
  logic         frame_valid, frame_valid6, overflow, overflow6;
  logic [2:0]   fifo_count, fifo_count6;
`ifdef FRAME_DROP_CNT_EN
  logic [15:0]  drop_cnt, drop_cnt6;
`endif
  int checks = 0, errors = 0;
  always #5 clock = ~clock;
  cluster_frame_collector #(.MXPASS(8), .MXADRBITS(11), .MXCNTBITS(3), .FIFO_DEPTH(4)) u8 (
    .clock(clock), .reset(reset), .found_in(found_in), .adr_in(adr_in), .cnt_in(cnt_in),
    .pass_in(pass_in), .frame_data(frame_data), .frame_valid(frame_valid),
    .frame_ready(frame_ready), .fifo_count(fifo_count), .overflow(overflow)
`ifdef FRAME_DROP_CNT_EN
    , .drop_cnt(drop_cnt)
`endif
  );
  cluster_frame_collector #(.MXPASS(6), .MXADRBITS(11), .MXCNTBITS(3), .FIFO_DEPTH(4)) u6 (
    .clock(clock), .reset(reset), .found_in(found_in), .adr_in(adr_in), .cnt_in(cnt_in),
    .pass_in(pass_in), .frame_data(frame_data6), .frame_valid(frame_valid6),
    .frame_ready(ready6), .fifo_count(fifo_count6), .overflow(overflow6)
`ifdef FRAME_DROP_CNT_EN
    , .drop_cnt(drop_cnt6)
`endif
  );
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  function automatic logic [127:0] ef8(input int hp, input int adr, input int cnt);
    logic [7:0][13:0] f;
    for (int k = 0; k < 8; k++) f[k] = (k == hp) ? {cnt[2:0], adr[10:0]} : INV;
    return 128'(f);
  endfunction
  function automatic logic [127:0] ef6(input int hp, input int adr, input int cnt);
    logic [5:0][13:0] f;
    for (int k = 0; k < 6; k++) f[k] = (k == hp) ? {cnt[2:0], adr[10:0]} : INV;
    return 128'(f);
  endfunction
  task automatic drive(input logic f, input int adr, input int cnt, input int p);
    found_in = f;
    adr_in   = f ? adr[10:0] : 11'h7FF;
    cnt_in   = f ? cnt[2:0] : 3'd0;
    pass_in  = p[2:0];
    @(posedge clock);
    #1;
  endtask
  task automatic run_part(input int hp, input int adr, input int cnt, input int first, input int last);
    for (int p = first; p <= last; p++) drive(p == hp, adr, cnt, p);
  endtask
  task automatic do_reset();
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
  endtask
  initial begin
    #1;
    @(posedge clock);
    #1;
    chk("reset_valid", 128'(frame_valid), 128'(0));
    chk("reset_count", 128'(fifo_count), 128'(0));
    chk("reset_overflow", 128'(overflow), 128'(0));
    chk("reset_data", 128'(frame_data), ef8(-1, 0, 0));
    reset = 1'b0;
    frame_ready = 1'b1;
    run_part(3, 500, 2, 0, 7);
    chk("single_valid", 128'(frame_valid), 128'(1));
    chk("single_data", 128'(frame_data), ef8(3, 500, 2));
    chk("single_count", 128'(fifo_count), 128'(1));
    drive(0, 0, 0, 0);
    chk("single_valid_drop", 128'(frame_valid), 128'(0));
    chk("single_count_zero", 128'(fifo_count), 128'(0));
    frame_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      run_part(i, 100 + i, i + 1, 0, 7);
      chk("bp_head", 128'(frame_data), ef8(0, 100, 1));
    end
    chk("bp_count", 128'(fifo_count), 128'(4));
    chk("bp_overflow", 128'(overflow), 128'(1));
`ifdef FRAME_DROP_CNT_EN
    chk("bp_drop_cnt", 128'(drop_cnt), 128'(1));
`endif
    frame_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("drain_valid", 128'(frame_valid), 128'(1));
      chk("drain_data", 128'(frame_data), ef8(i, 100 + i, i + 1));
      drive(0, 0, 0, 0);
    end
    chk("drain_empty", 128'(fifo_count), 128'(0));
    chk("drain_overflow_sticky", 128'(overflow), 128'(1));
    frame_ready = 1'b0;
    do_reset();
    chk("ovf_cleared", 128'(overflow), 128'(0));
    for (int i = 0; i < 4; i++) run_part(i, 200 + i, i + 2, 0, 7);
    chk("full_count", 128'(fifo_count), 128'(4));
    run_part(6, 600, 5, 0, 6);
    frame_ready = 1'b1;
    drive(0, 0, 0, 7);
    chk("pushpop_count", 128'(fifo_count), 128'(4));
    chk("pushpop_overflow", 128'(overflow), 128'(0));
`ifdef FRAME_DROP_CNT_EN
    chk("pushpop_drop_cnt", 128'(drop_cnt), 128'(0));
`endif
    for (int i = 1; i < 4; i++) begin
      chk("pushpop_order", 128'(frame_data), ef8(i, 200 + i, i + 2));
      drive(0, 0, 0, 0);
    end
    chk("pushpop_last", 128'(frame_data), ef8(6, 600, 5));
    drive(0, 0, 0, 0);
    chk("pushpop_empty", 128'(fifo_count), 128'(0));
    frame_ready = 1'b0;
    do_reset();
    run_part(2, 222, 3, 0, 7);
    for (int c = 0; c < 20; c++) begin
      drive(c % 8 == 5, 300 + c, 1, c % 8);
      chk("hold_data", 128'(frame_data), ef8(2, 222, 3));
    end
    chk("hold_count", 128'(fifo_count), 128'(3));
    frame_ready = 1'b1;
    drive(0, 0, 0, 0);
    frame_ready = 1'b0;
    chk("pre_reset_count", 128'(fifo_count), 128'(2));
    run_part(1, 77, 4, 0, 4);
    reset = 1'b1;
    #1;
    chk("midrst_valid", 128'(frame_valid), 128'(0));
    chk("midrst_count", 128'(fifo_count), 128'(0));
    chk("midrst_overflow", 128'(overflow), 128'(0));
    chk("midrst_data", 128'(frame_data), ef8(-1, 0, 0));
    @(negedge clock);
    reset = 1'b0;
    run_part(-1, 0, 0, 5, 7);
    chk("partial_valid", 128'(frame_valid), 128'(1));
    chk("partial_data", 128'(frame_data), ef8(-1, 0, 0));
    frame_ready = 1'b1;
    run_part(0, 1234, 7, 0, 7);
    chk("post_rst_data", 128'(frame_data), ef8(0, 1234, 7));
    chk("post_rst_count", 128'(fifo_count), 128'(1));
    frame_ready = 1'b0;
    do_reset();
    drive(1, 100, 1, 7);
    chk("tag7_no_push", 128'(fifo_count6), 128'(0));
    drive(1, 101, 2, 6);
    chk("tag6_no_push", 128'(fifo_count6), 128'(0));
    drive(0, 0, 0, 5);
    chk("tag_close_count", 128'(fifo_count6), 128'(1));
    chk("tag_no_slot_change", 128'(frame_data6), ef6(-1, 0, 0));
    run_part(0, 9, 1, 0, 5);
    chk("m6_count", 128'(fifo_count6), 128'(2));
    ready6 = 1'b1;
    drive(0, 0, 0, 0);
    ready6 = 1'b0;
    chk("m6_frame", 128'(frame_data6), ef6(0, 9, 1));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
